// File: rtl/sort_ctrl.sv
// Job sequencer and memory-port owner for the bubble-sort engine: load, length write, sort, drain.
// Optional SORT-state cycle counter is built when SORT_CTRL_CYCLE_CNT_EN is defined.
module sort_ctrl #(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned addrWidth = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [addrWidth-1:0] cmd_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [dataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [dataWidth-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err,
    output logic [31:0]          sort_cycles,
    output logic                 sort_start,
    input  logic                 sort_finish,
    output logic                 sort_rst,
    input  logic [addrWidth-1:0] eng_raddr,
    input  logic [addrWidth-1:0] eng_waddr,
    input  logic [dataWidth-1:0] eng_wdata,
    input  logic                 eng_wen,
    output logic [addrWidth-1:0] mem_raddr,
    output logic [addrWidth-1:0] mem_waddr,
    output logic [dataWidth-1:0] mem_wdata,
    output logic                 mem_wen,
    input  logic [dataWidth-1:0] mem_rdata
);

    localparam logic [addrWidth-1:0] Top     = '1;
    localparam logic [addrWidth-1:0] AddrOne = addrWidth'(1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StLen, StPrime, StSort, StErst, StDrainRd, StDrainOut
    } state_e;

    state_e               state_q;
    logic [addrWidth-1:0] len_q;
    logic [addrWidth-1:0] wcnt_q;
    logic [addrWidth-1:0] rcnt_q;
    logic [dataWidth-1:0] out_q;
    logic                 fresh_q;
    logic                 err_q;
    logic                 last;
    logic                 wen;

    assign last = (rcnt_q == (len_q - AddrOne));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            out_q   <= '0;
            fresh_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= 1'b0;
            fresh_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        len_q  <= cmd_len;
                        wcnt_q <= '0;
                        rcnt_q <= '0;
                        if (cmd_len == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        wcnt_q <= wcnt_q + AddrOne;
                        if (wcnt_q == (len_q - AddrOne)) begin
                            state_q <= StLen;
                        end
                    end
                end
                StLen: begin
                    state_q <= (len_q == AddrOne) ? StDrainRd : StPrime;
                end
                StPrime: begin
                    state_q <= StSort;
                end
                StSort: begin
                    if (sort_finish) begin
                        state_q <= StErst;
                    end
                end
                StErst: begin
                    state_q <= StDrainRd;
                end
                StDrainRd: begin
                    state_q <= StDrainOut;
                    fresh_q <= 1'b1;
                end
                StDrainOut: begin
                    // Read data is only valid in the first DRAIN_OUT cycle; keep a copy after that.
                    if (fresh_q) begin
                        out_q <= mem_rdata;
                    end
                    if (out_ready) begin
                        if (last) begin
                            state_q <= StIdle;
                        end else begin
                            rcnt_q  <= rcnt_q + AddrOne;
                            state_q <= StDrainRd;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The engine only sees the memory during SORT; it keeps writing after Finish.
    always_comb begin
        mem_raddr = Top;
        mem_waddr = Top;
        mem_wdata = '0;
        wen       = 1'b0;
        case (state_q)
            StLoad: begin
                wen       = in_valid;
                mem_waddr = wcnt_q;
                mem_wdata = in_data;
            end
            StLen: begin
                wen       = 1'b1;
                mem_waddr = Top;
                mem_wdata = dataWidth'(len_q);
            end
            StSort: begin
                mem_raddr = eng_raddr;
                mem_waddr = eng_waddr;
                mem_wdata = eng_wdata;
                wen       = eng_wen;
            end
            StDrainRd: begin
                mem_raddr = rcnt_q;
            end
            default: begin
            end
        endcase
    end

    assign mem_wen    = wen & ~rst;
    assign cmd_ready  = (state_q == StIdle) & ~rst;
    assign in_ready   = (state_q == StLoad) & ~rst;
    assign out_valid  = (state_q == StDrainOut) & ~rst;
    assign out_last   = (state_q == StDrainOut) & last & ~rst;
    assign out_data   = ((state_q == StDrainOut) && fresh_q) ? mem_rdata : out_q;
    assign busy       = (state_q != StIdle) & ~rst;
    assign err        = err_q & ~rst;
    assign sort_start = (state_q == StSort) & ~rst;
    assign sort_rst   = rst | (state_q == StErst);

`ifdef SORT_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else if ((state_q == StIdle) && cmd_valid && (cmd_len != '0)) begin
            cyc_q <= '0;
        end else if ((state_q == StSort) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign sort_cycles = cyc_q;
`else
    assign sort_cycles = '0;
`endif

endmodule

// File: tb/tb_sort_ctrl.sv
// Random-stimulus bench for sort_ctrl with a behavioural memory and sort engine stand-in.
// Expected output is the sorted input list, checked by a scoreboard monitor on the result stream.
module tb_sort_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam logic [AW-1:0] TOP = '1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          err;
    logic [31:0]   sort_cycles;
    logic          sort_start;
    logic          sort_finish;
    logic          sort_rst;
    logic [AW-1:0] eng_raddr;
    logic [AW-1:0] eng_waddr;
    logic [DW-1:0] eng_wdata;
    logic          eng_wen;
    logic [AW-1:0] mem_raddr;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic [DW-1:0] mem_rdata;

    sort_ctrl #(.dataWidth(DW), .addrWidth(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err), .sort_cycles(sort_cycles),
        .sort_start(sort_start), .sort_finish(sort_finish), .sort_rst(sort_rst),
        .eng_raddr(eng_raddr), .eng_waddr(eng_waddr), .eng_wdata(eng_wdata), .eng_wen(eng_wen),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, required event within bound", name);
    endfunction

    // Memory: synchronous read, 1-cycle latency, read-before-write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    // Engine stand-in: read length at Start, read all words, sort, write back, raise Finish,
    // then keep writing junk until reset.
    int est = 0;
    int en;
    int eidx;
    int eph;
    logic [DW-1:0] ebuf [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sort_rst) begin
            est = 0;
            sort_finish <= 1'b0;
            eng_wen     <= 1'b0;
            eng_raddr   <= '0;
            eng_waddr   <= '0;
            eng_wdata   <= '0;
        end else begin
            case (est)
                0: if (sort_start) begin
                    en = int'(mem_rdata[AW-1:0]);
                    eidx = 0;
                    eph = 0;
                    eng_raddr <= '0;
                    est = 1;
                end
                1: begin
                    if (eph == 0) begin
                        eph = 1;
                    end else begin
                        ebuf[eidx] = mem_rdata;
                        eph = 0;
                        eidx++;
                        if (eidx >= en) begin
                            for (int i = 1; i < en; i++) begin
                                logic [DW-1:0] k;
                                int j;
                                k = ebuf[i];
                                j = i - 1;
                                while (j >= 0 && $signed(ebuf[j]) > $signed(k)) begin
                                    ebuf[j+1] = ebuf[j];
                                    j--;
                                end
                                ebuf[j+1] = k;
                            end
                            eidx = 0;
                            est = 2;
                        end else begin
                            eng_raddr <= AW'(eidx);
                        end
                    end
                end
                2: begin
                    eng_wen   <= 1'b1;
                    eng_waddr <= AW'(eidx);
                    eng_wdata <= ebuf[eidx];
                    eidx++;
                    if (eidx >= en) est = 3;
                end
                3: begin
                    eng_wen     <= 1'b0;
                    sort_finish <= 1'b1;
                    est = 4;
                end
                default: begin
                    eng_wen   <= 1'b1;
                    eng_waddr <= '0;
                    eng_wdata <= 32'hDEAD_BEEF;
                end
            endcase
        end
    end

    // Scoreboard.
    int exp_q[$];
    bit exp_last[$];
    int hold_data;
    bit hold_pend = 1'b0;
    int err_cnt = 0;
    int inr_cnt = 0;
    int cmdlow_cnt = 0;
    int start_cnt = 0;

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (in_ready) inr_cnt++;
        if (!cmd_ready) cmdlow_cnt++;
        if (sort_start) start_cnt++;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_data", longint'($signed(out_data)), longint'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = int'(out_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got word %0d, required no output",
                             $signed(out_data));
                end else begin
                    int e;
                    bit l;
                    e = exp_q.pop_front();
                    l = exp_last.pop_front();
                    chk("out_data", longint'($signed(out_data)), longint'(e));
                    chk("out_last", longint'(out_last), longint'(l));
                end
            end
        end
    end

    bit bp_en = 1'b0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    int  stim[$];
    bit  gaps = 1'b0;
    logic [31:0] cyc_after_accept;

    function automatic int rnd_word();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    task automatic run_job(input int n, input bit expect_out);
        int s[$];
        int t;
        if (expect_out) begin
            s = stim;
            for (int i = 1; i < n; i++) begin
                int k;
                int j;
                k = s[i];
                j = i - 1;
                while (j >= 0 && s[j] > k) begin
                    s[j+1] = s[j];
                    j--;
                end
                s[j+1] = k;
            end
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(s[i]);
                exp_last.push_back(i == n - 1);
            end
        end
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) fail("cmd_ready_wait");
        cmd_valid = 1'b1;
        cmd_len = AW'(n);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        cyc_after_accept = sort_cycles;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = stim[i];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                fail("in_ready_wait");
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || busy) fail("job_done_wait");
        else chk("cmd_ready_after_job", longint'(cmd_ready), 1);
    endtask

    initial begin
        int s0;
        int e0;
        int i0;
        int c0;
        int t;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_sort_start", longint'(sort_start), 0);
        chk("rst_mem_wen", longint'(mem_wen), 0);
        chk("rst_sort_rst", longint'(sort_rst), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", longint'(cmd_ready), 1);
        chk("post_rst_sort_cycles", longint'(sort_cycles), 0);
        chk("post_rst_out_data", longint'(out_data), 0);
        chk("post_rst_sort_rst", longint'(sort_rst), 0);

        // Basic job with duplicates and negatives.
        stim = {7, -3, 0, 12, -3};
        s0 = start_cnt;
        run_job(5, 1'b1);
        wait_idle();
        chk("len5_mem_top", longint'(mem[TOP]), 5);
        chk("len5_busy_after", longint'(busy), 0);
        chk("len5_sorted", longint'(start_cnt > s0), 1);

        // Single word bypasses the engine.
        stim = {42};
        s0 = start_cnt;
        run_job(1, 1'b1);
        wait_idle();
        chk("len1_no_start", longint'(start_cnt - s0), 0);

        // Zero-length command is rejected.
        @(negedge clk);
        e0 = err_cnt;
        i0 = inr_cnt;
        c0 = cmdlow_cnt;
        cmd_valid = 1'b1;
        cmd_len = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("len0_err_pulses", longint'(err_cnt - e0), 1);
        chk("len0_no_in_ready", longint'(inr_cnt - i0), 0);
        chk("len0_cmd_ready_low", longint'(cmdlow_cnt - c0), 0);

        // Descending data under output backpressure.
        bp_en = 1'b1;
        stim = {};
        for (int i = 8; i >= 1; i--) stim.push_back(i);
        run_job(8, 1'b1);
        wait_idle();

        // Reset in the middle of SORT abandons the job.
        stim = {};
        for (int i = 0; i < 6; i++) stim.push_back(rnd_word());
        run_job(6, 1'b0);
        t = 0;
        @(negedge clk);
        while (!sort_start && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!sort_start) fail("sort_start_wait");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_sort_rst", longint'(sort_rst), 1);
        chk("midrst_sort_start", longint'(sort_start), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_busy", longint'(busy), 0);
        chk("midrst_idle_cmd_ready", longint'(cmd_ready), 1);
        stim = {3, 1, 2};
        run_job(3, 1'b1);
        wait_idle();

        // Cycle counter.
        stim = {4, 3, 2, 1};
        run_job(4, 1'b1);
        wait_idle();
`ifdef SORT_CTRL_CYCLE_CNT_EN
        chk("sort_cycles_nonzero", longint'(sort_cycles != 0), 1);
`else
        chk("sort_cycles_tied", longint'(sort_cycles), 0);
`endif
        stim = {5, -5, 9};
        run_job(3, 1'b1);
        chk("sort_cycles_cleared", longint'(cyc_after_accept), 0);
        wait_idle();

        // Random jobs with input gaps and backpressure.
        gaps = 1'b1;
        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(1, 12));
            stim = {};
            for (int i = 0; i < n; i++) stim.push_back(rnd_word());
            run_job(n, 1'b1);
            wait_idle();
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort_ctrl.md
# sort_ctrl

Job sequencer and memory-port owner for the bubble-sort engine. It accepts a sort command, loads the data words from a valid/ready stream into the shared single-port-pair data memory and writes the length word. It then starts the engine, owns memory access while the engine runs, and detects completion. Finally it resets the engine and streams the sorted words back out. It sits between the host-side streams and the memory/sort-engine pair.

## Interface
Parameters:
- dataWidth, 32, data word width (matches engine)
- addrWidth, 10, memory address width; TOP = all-ones address holds the length word

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  addrWidth  number of words N (0..2^addrWidth-1)
- in_valid / in_ready  in / out  1  load stream handshake
- in_data  in  dataWidth  signed load word
- out_valid / out_ready  out / in  1  result stream handshake
- out_data  out  dataWidth  signed sorted word
- out_last  out  1  marks the final result word
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on rejected command
- sort_cycles  out  32  SORT-state cycle count (see Configuration)
- sort_start  out  1  engine Start; held high for the whole of SORT
- sort_finish  in  1  engine Finish
- sort_rst  out  1  engine reset
- eng_raddr / eng_waddr  in  addrWidth  engine addresses
- eng_wdata  in  dataWidth  engine write data
- eng_wen  in  1  engine write enable
- mem_raddr / mem_waddr  out  addrWidth  memory addresses
- mem_wdata  out  dataWidth  memory write data
- mem_wen  out  1  memory write enable
- mem_rdata  in  dataWidth  memory read data; synchronous, 1-cycle latency; fanned out directly to engine RData as well

## Operation
States: IDLE, LOAD, LEN, PRIME, SORT, ERST, DRAIN_RD, DRAIN_OUT.
- IDLE: cmd_ready=1. On cmd_valid, latch len=cmd_len and clear wcnt/rcnt.
  - len==0: err=1 for one cycle; stay in IDLE.
  - Otherwise go to LOAD.
- LOAD: in_ready=1. Each accepted word: mem_wen=1, mem_waddr=wcnt, mem_wdata=in_data (combinational), wcnt+1. Acceptance with wcnt==len-1 goes to LEN.
- LEN: mem_wen=1, mem_waddr=TOP, mem_wdata=zero-extended len.
  - len>=2: go to PRIME.
  - len==1: go to DRAIN_RD; no sort.
- PRIME: one cycle with mem_raddr=TOP so the engine samples the length at Start; then go to SORT.
- SORT:
  - sort_start=1.
  - mem_raddr/waddr/wdata/wen are driven from the eng_* inputs.
  - sort_finish sampled high goes to ERST.
- ERST: sort_rst=1, mem_wen=0, engine writes discarded; go to DRAIN_RD.
- DRAIN_RD: mem_raddr=rcnt; go to DRAIN_OUT.
- DRAIN_OUT: capture out_data=mem_rdata on entry and hold it stable.
  - out_valid=1; out_last=(rcnt==len-1).
  - On out_ready: if last, go to IDLE; else rcnt+1 and go to DRAIN_RD.
- Outside SORT: mem_wen is driven only by LOAD/LEN, and mem_raddr=TOP except in DRAIN_RD.
- sort_rst = rst OR (state==ERST). The engine loops writing after Finish, so the SORT-only mux and the ERST reset are mandatory.

## Timing
- Reset: state=IDLE; counters=0; out_data=0; sort_cycles=0.
  - While rst is high: out_valid, out_last, in_ready, err, busy, sort_start, mem_wen all 0; sort_rst=1.
  - First cycle after rst deasserts: cmd_ready=1.
- Command acceptance to LOAD: 1 cycle. Load: 1 word/cycle under continuous in_valid.
- Last load word to sort_start high: 3 cycles (LEN, PRIME, then SORT).
- sort_finish high at posedge to sort_rst high: next cycle; sort_start drops in that same cycle.
- Drain: 2 cycles per word minimum; out_valid stays high, with out_data stable, until out_ready.
- Final out handshake to cmd_ready=1: next cycle.
- rst mid-job: return to IDLE next cycle, engine reset. Memory contents are left as is; no further result words are emitted.
- cmd_valid outside IDLE is ignored (not acknowledged).

## Configuration
- SORT_CTRL_CYCLE_CNT_EN defined:
  - sort_cycles clears on command acceptance.
  - It increments every cycle in SORT and holds after SORT, saturating at 2^32-1.
- SORT_CTRL_CYCLE_CNT_EN undefined: counter not built; sort_cycles tied to 0.

## Test plan
- len=5, data 7,-3,0,12,-3 -> mem[TOP]=5; out -3,-3,0,7,12; out_last only on 12; busy low afterwards.
- len=1, data 42 -> sort_start never high; single out 42 with out_last=1.
- cmd_len=0 -> err high exactly one cycle; no in_ready; cmd_ready stays 1.
- len=8, data 8..1 descending, random out_ready backpressure -> out 1..8; out_data constant while out_valid && !out_ready.
- rst asserted mid-SORT for one cycle -> sort_rst=1, state IDLE next cycle; a following len=3 job (3,1,2) returns 1,2,3.
- Macro defined, len=4 descending -> sort_cycles nonzero and reset by the next command. Macro undefined -> sort_cycles always 0.
